// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: fetch (I) and data (D) share one memory port.
// Round-robin on ties, registered memory command, back-to-back handoff on mem_resp.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        I_mem_read,
  input  logic [15:0] I_mem_address,
  output logic        I_mem_resp,
  output logic [15:0] I_mem_rdata,
  input  logic        D_mem_read,
  input  logic        D_mem_write,
  input  logic [15:0] D_mem_address,
  input  logic [15:0] D_mem_wdata,
  input  logic [1:0]  D_mem_byte_enable,
  output logic        D_mem_resp,
  output logic [15:0] D_mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } cmd_t;

  state_t state, state_nxt;
  side_t  last_grant, last_grant_nxt;
  cmd_t   cmd, cmd_nxt;
  cmd_t   cmd_i, cmd_d;
  logic   pend_i, pend_d;

  assign pend_i = I_mem_read;
  assign pend_d = D_mem_read | D_mem_write;

  // Candidate commands; a simultaneous D read+write collapses to a write.
  always_comb begin
    cmd_i      = '0;
    cmd_i.rd   = 1'b1;
    cmd_i.addr = I_mem_address;
    cmd_d       = '0;
    cmd_d.rd    = D_mem_read & ~D_mem_write;
    cmd_d.wr    = D_mem_write;
    cmd_d.addr  = D_mem_address;
    cmd_d.wdata = D_mem_wdata;
    cmd_d.be    = D_mem_byte_enable;
  end

  always_comb begin
    state_nxt      = state;
    cmd_nxt        = cmd;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (pend_d && (!pend_i || last_grant == SIDE_I)) begin
          state_nxt = SERVE_D;
          cmd_nxt   = cmd_d;
        end else if (pend_i) begin
          state_nxt = SERVE_I;
          cmd_nxt   = cmd_i;
        end
      end
      SERVE_I: begin
        if (mem_resp) begin
          last_grant_nxt = SIDE_I;
          // I's own request is not re-considered in its completion cycle.
          if (pend_d) begin
            state_nxt = SERVE_D;
            cmd_nxt   = cmd_d;
          end else begin
            state_nxt = IDLE;
            cmd_nxt   = '0;
          end
        end
      end
      SERVE_D: begin
        if (mem_resp) begin
          last_grant_nxt = SIDE_D;
          if (pend_i) begin
            state_nxt = SERVE_I;
            cmd_nxt   = cmd_i;
          end else begin
            state_nxt = IDLE;
            cmd_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cmd_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= SIDE_I;
      cmd        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cmd        <= cmd_nxt;
    end
  end

  assign mem_read        = cmd.rd;
  assign mem_write       = cmd.wr;
  assign mem_address     = cmd.addr;
  assign mem_wdata       = cmd.wdata;
  assign mem_byte_enable = cmd.be;

  // A requester that has dropped its request gets no response; the access still completes.
  assign I_mem_resp  = ~reset & (state == SERVE_I) & mem_resp & pend_i;
  assign D_mem_resp  = ~reset & (state == SERVE_D) & mem_resp & pend_d;
  assign I_mem_rdata = mem_rdata;
  assign D_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level requester/memory model.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        I_mem_read;
  logic [15:0] I_mem_address;
  logic        I_mem_resp;
  logic [15:0] I_mem_rdata;
  logic        D_mem_read, D_mem_write;
  logic [15:0] D_mem_address, D_mem_wdata;
  logic [1:0]  D_mem_byte_enable;
  logic        D_mem_resp;
  logic [15:0] D_mem_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .I_mem_read(I_mem_read), .I_mem_address(I_mem_address),
    .I_mem_resp(I_mem_resp), .I_mem_rdata(I_mem_rdata),
    .D_mem_read(D_mem_read), .D_mem_write(D_mem_write),
    .D_mem_address(D_mem_address), .D_mem_wdata(D_mem_wdata),
    .D_mem_byte_enable(D_mem_byte_enable),
    .D_mem_resp(D_mem_resp), .D_mem_rdata(D_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, well before the falling edge.
  task automatic settle();
    #3;
  endtask

  task automatic quiet();
    I_mem_read = 0; I_mem_address = '0;
    D_mem_read = 0; D_mem_write = 0; D_mem_address = '0;
    D_mem_wdata = '0; D_mem_byte_enable = '0;
    mem_resp = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    quiet();
    nxt(); nxt();
    reset = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_mrd"}, mem_read, 0);
    chk({tag, "_mwr"}, mem_write, 0);
    chk({tag, "_madr"}, mem_address, 0);
    chk({tag, "_mwd"}, mem_wdata, 0);
    chk({tag, "_mbe"}, mem_byte_enable, 0);
    chk({tag, "_iresp"}, I_mem_resp, 0);
    chk({tag, "_dresp"}, D_mem_resp, 0);
  endtask

  // Random-phase model state
  logic [15:0] mem_m [0:255];
  bit          i_act, d_act, mbusy, resp_now;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_be;
  int          d_op, i_wait, d_wait, mlat;
  logic [15:0] merged;

  initial begin
    reset = 1;
    quiet();
    do_reset();

    // Reset state: IDLE, everything quiet.
    settle();
    chk_idle("rst");

    // Lone I read of 0x1000, mem_resp two cycles after mem_read.
    I_mem_read = 1; I_mem_address = 16'h1000;
    settle(); chk("s1_c0_mrd", mem_read, 0);
    nxt(); settle();
    chk("s1_c1_mrd", mem_read, 1); chk("s1_c1_adr", mem_address, 16'h1000);
    chk("s1_c1_iresp", I_mem_resp, 0); chk("s1_c1_dresp", D_mem_resp, 0);
    nxt(); settle();
    chk("s1_c2_adr", mem_address, 16'h1000); chk("s1_c2_iresp", I_mem_resp, 0);
    nxt(); mem_resp = 1; mem_rdata = 16'h1234; settle();
    chk("s1_c3_iresp", I_mem_resp, 1); chk("s1_c3_rdata", I_mem_rdata, 16'h1234);
    chk("s1_c3_dresp", D_mem_resp, 0);
    nxt(); I_mem_read = 0; mem_resp = 0; settle();
    chk("s1_c4_iresp", I_mem_resp, 0); chk("s1_c4_mrd", mem_read, 0);

    // Tie after reset: D (write) wins, I follows without an IDLE bubble.
    do_reset();
    D_mem_write = 1; D_mem_address = 16'h2002; D_mem_wdata = 16'hBEEF; D_mem_byte_enable = 2'b10;
    I_mem_read = 1; I_mem_address = 16'h0040;
    nxt(); mem_resp = 1; settle();
    chk("s2_c1_mwr", mem_write, 1); chk("s2_c1_mrd", mem_read, 0);
    chk("s2_c1_adr", mem_address, 16'h2002); chk("s2_c1_wd", mem_wdata, 16'hBEEF);
    chk("s2_c1_be", mem_byte_enable, 2'b10);
    chk("s2_c1_dresp", D_mem_resp, 1); chk("s2_c1_iresp", I_mem_resp, 0);
    nxt(); D_mem_write = 0; settle();
    chk("s2_c2_mrd", mem_read, 1); chk("s2_c2_mwr", mem_write, 0);
    chk("s2_c2_adr", mem_address, 16'h0040);
    chk("s2_c2_iresp", I_mem_resp, 1); chk("s2_c2_dresp", D_mem_resp, 0);
    nxt(); I_mem_read = 0; mem_resp = 0; settle();
    chk("s2_c3_mrd", mem_read, 0);

    // D_mem_read held across two accesses (0x3000 then 0x4A4A).
    D_mem_read = 1; D_mem_address = 16'h3000;
    nxt(); mem_resp = 1; mem_rdata = 16'h5555; settle();
    chk("s3_c1_adr", mem_address, 16'h3000); chk("s3_c1_dresp", D_mem_resp, 1);
    chk("s3_c1_rdata", D_mem_rdata, 16'h5555);
    nxt(); D_mem_address = 16'h4A4A; mem_resp = 0; settle();
    chk("s3_c2_mrd", mem_read, 0); chk("s3_c2_dresp", D_mem_resp, 0);
    nxt(); mem_resp = 1; settle();
    chk("s3_c3_mrd", mem_read, 1); chk("s3_c3_adr", mem_address, 16'h4A4A);
    chk("s3_c3_dresp", D_mem_resp, 1);
    nxt(); D_mem_read = 0; mem_resp = 0; settle();
    chk("s3_c4_mrd", mem_read, 0);

    // I abandons its request mid-access; access completes silently.
    I_mem_read = 1; I_mem_address = 16'h0777;
    nxt(); settle();
    chk("s4_c1_adr", mem_address, 16'h0777);
    nxt(); I_mem_read = 0; I_mem_address = 16'hFFFF; settle();
    chk("s4_c2_mrd", mem_read, 1); chk("s4_c2_adr", mem_address, 16'h0777);
    nxt(); mem_resp = 1; settle();
    chk("s4_c3_adr", mem_address, 16'h0777); chk("s4_c3_iresp", I_mem_resp, 0);
    nxt(); mem_resp = 0; settle();
    chk("s4_c4_mrd", mem_read, 0);

    // Reset during SERVE_D, late mem_resp afterwards.
    D_mem_read = 1; D_mem_address = 16'h5000;
    nxt(); settle();
    chk("s5_c1_mrd", mem_read, 1);
    nxt(); reset = 1;
    nxt(); reset = 0; D_mem_read = 0; mem_resp = 1; settle();
    chk_idle("s5_c3");
    nxt(); mem_resp = 0;

    // Continuous contention: grants alternate D,I,D,I,...
    do_reset();
    I_mem_read = 1; I_mem_address = 16'h1111;
    D_mem_read = 1; D_mem_address = 16'h2222;
    for (int k = 1; k <= 8; k++) begin
      nxt(); mem_resp = 1; settle();
      chk($sformatf("s6_%0d_dresp", k), D_mem_resp, (k % 2 == 1));
      chk($sformatf("s6_%0d_iresp", k), I_mem_resp, (k % 2 == 0));
      chk($sformatf("s6_%0d_adr", k), mem_address, (k % 2 == 1) ? 16'h2222 : 16'h1111);
    end

    // Randomized traffic: well-behaved requesters, random-latency memory.
    do_reset();
    for (int a = 0; a < 256; a++) mem_m[a] = 16'($urandom);
    i_act = 0; d_act = 0; mbusy = 0; mlat = 0; i_wait = 0; d_wait = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      nxt();
      if (!i_act && cyc < 550 && $urandom_range(0, 2) == 0) begin
        i_act = 1; i_addr = 16'($urandom_range(0, 255)); i_wait = 0;
      end
      if (!d_act && cyc < 550 && $urandom_range(0, 2) == 0) begin
        d_act = 1; d_addr = 16'($urandom_range(0, 255)); d_wait = 0;
        d_op = $urandom_range(0, 2); d_wdata = 16'($urandom); d_be = 2'($urandom);
      end
      I_mem_read = i_act; I_mem_address = i_addr;
      D_mem_read = d_act && (d_op != 1); D_mem_write = d_act && (d_op != 0);
      D_mem_address = d_addr; D_mem_wdata = d_wdata; D_mem_byte_enable = d_be;
      if (!mbusy && (mem_read || mem_write)) begin
        mbusy = 1; mlat = $urandom_range(0, 3);
      end
      resp_now = mbusy && (mlat == 0);
      mem_resp = resp_now;
      mem_rdata = mem_m[mem_address[7:0]];
      if (mbusy && mlat > 0) mlat--;
      settle();
      if (resp_now) chk("r_onehot", {31'b0, I_mem_resp} + {31'b0, D_mem_resp}, 1);
      if (I_mem_resp) begin
        chk("r_i_act", i_act, 1);
        chk("r_i_adr", mem_address, i_addr);
        chk("r_i_op", {mem_read, mem_write}, 2'b10);
        chk("r_i_rdata", I_mem_rdata, mem_m[i_addr[7:0]]);
        chk("r_i_wait", i_wait <= 12, 1);
        i_act = 0;
      end
      if (D_mem_resp) begin
        chk("r_d_act", d_act, 1);
        chk("r_d_adr", mem_address, d_addr);
        if (d_op == 0) begin
          chk("r_d_op", {mem_read, mem_write}, 2'b10);
          chk("r_d_rdata", D_mem_rdata, mem_m[d_addr[7:0]]);
        end else begin
          chk("r_d_op", {mem_read, mem_write}, 2'b01);
          chk("r_d_wd", mem_wdata, d_wdata);
          chk("r_d_be", mem_byte_enable, d_be);
          merged = mem_m[d_addr[7:0]];
          if (d_be[0]) merged[7:0]  = d_wdata[7:0];
          if (d_be[1]) merged[15:8] = d_wdata[15:8];
          mem_m[d_addr[7:0]] = merged;
        end
        chk("r_d_wait", d_wait <= 12, 1);
        d_act = 0;
      end
      if (resp_now) mbusy = 0;
      if (i_act) i_wait++;
      if (d_act) d_wait++;
    end
    chk("r_drained", {30'b0, i_act, d_act}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
